// File: rtl/armleocpu_axi_lite_initiator.sv
// Single-outstanding AXI4-Lite manager: turns a simple request/response port into
// AXI4-Lite reads and writes, rejecting misaligned addresses without bus traffic.
module armleocpu_axi_lite_initiator #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_wstrb,

  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic [1:0]            resp_resp,

  output logic [ADDR_WIDTH-1:0] AXI_AWADDR,
  output logic                  AXI_AWVALID,
  input  logic                  AXI_AWREADY,

  output logic [31:0]           AXI_WDATA,
  output logic [3:0]            AXI_WSTRB,
  output logic                  AXI_WVALID,
  input  logic                  AXI_WREADY,

  input  logic [1:0]            AXI_BRESP,
  input  logic                  AXI_BVALID,
  output logic                  AXI_BREADY,

  output logic [ADDR_WIDTH-1:0] AXI_ARADDR,
  output logic                  AXI_ARVALID,
  input  logic                  AXI_ARREADY,

  input  logic [31:0]           AXI_RDATA,
  input  logic [1:0]            AXI_RRESP,
  input  logic                  AXI_RVALID,
  output logic                  AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE_REQ,
    WRITE_RESP,
    READ_REQ,
    READ_DATA,
    RESPOND
  } state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_done_now;
  logic   w_done_now;

  // A channel counts as done if it completed earlier or handshakes this cycle.
  assign aw_done_now = aw_done | (AXI_AWVALID & AXI_AWREADY);
  assign w_done_now  = w_done  | (AXI_WVALID  & AXI_WREADY);
  assign req_ready   = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'd0;
      resp_resp   <= 2'b00;
      AXI_AWADDR  <= '0;
      AXI_AWVALID <= 1'b0;
      AXI_WDATA   <= 32'd0;
      AXI_WSTRB   <= 4'd0;
      AXI_WVALID  <= 1'b0;
      AXI_BREADY  <= 1'b0;
      AXI_ARADDR  <= '0;
      AXI_ARVALID <= 1'b0;
      AXI_RREADY  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            resp_rdata <= 32'd0;
            if (req_addr[1:0] != 2'b00) begin
              resp_valid <= 1'b1;
              resp_resp  <= 2'b10;
              state      <= RESPOND;
            end else if (req_write) begin
              AXI_AWADDR  <= req_addr;
              AXI_WDATA   <= req_wdata;
              AXI_WSTRB   <= req_wstrb;
              AXI_AWVALID <= 1'b1;
              AXI_WVALID  <= 1'b1;
              aw_done     <= 1'b0;
              w_done      <= 1'b0;
              state       <= WRITE_REQ;
            end else begin
              AXI_ARADDR  <= req_addr;
              AXI_ARVALID <= 1'b1;
              state       <= READ_REQ;
            end
          end
        end
        WRITE_REQ: begin
          if (AXI_AWVALID && AXI_AWREADY) begin
            AXI_AWVALID <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (AXI_WVALID && AXI_WREADY) begin
            AXI_WVALID <= 1'b0;
            w_done     <= 1'b1;
          end
          if (aw_done_now && w_done_now) begin
            AXI_BREADY <= 1'b1;
            state      <= WRITE_RESP;
          end
        end
        WRITE_RESP: begin
          if (AXI_BVALID && AXI_BREADY) begin
            AXI_BREADY <= 1'b0;
            resp_valid <= 1'b1;
            resp_resp  <= AXI_BRESP;
            resp_rdata <= 32'd0;
            state      <= RESPOND;
          end
        end
        READ_REQ: begin
          if (AXI_ARVALID && AXI_ARREADY) begin
            AXI_ARVALID <= 1'b0;
            AXI_RREADY  <= 1'b1;
            state       <= READ_DATA;
          end
        end
        READ_DATA: begin
          if (AXI_RVALID && AXI_RREADY) begin
            AXI_RREADY <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= AXI_RDATA;
            resp_resp  <= AXI_RRESP;
            state      <= RESPOND;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_armleocpu_axi_lite_initiator.sv
// Scoreboarded bench: directed requests push expected responses, a monitor pops and
// checks them; a configurable responder model applies per-channel wait states.
module tb_armleocpu_axi_lite_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_resp;
  logic [15:0] awaddr, araddr;
  logic        awvalid, awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0, bready;
  logic        arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0, rready;

  armleocpu_axi_lite_initiator #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_resp(resp_resp),
    .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
    .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
    .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
    .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
    .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // Responder configuration and observation counters
  int cfg_aw_delay = 0, cfg_w_delay = 0, cfg_b_delay = 0, cfg_ar_delay = 0, cfg_r_delay = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;
  bit          cfg_spurious = 1'b0;
  int aw_cycles = 0, w_cycles = 0, ar_cycles = 0, b_count = 0;

  // Responder model, evaluated once per cycle on the falling edge.
  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit aw_got, w_got, ar_got, aw_hs, w_hs, b_hs, ar_hs, r_hs, spur_prev;
    logic        p_awvalid, p_wvalid, p_arvalid;
    logic [15:0] p_awaddr, p_araddr;
    logic [35:0] p_w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; spur_prev = 0;
        p_awvalid = 0; p_wvalid = 0; p_arvalid = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        continue;
      end
      if (aw_hs) aw_got = 1;
      if (w_hs) w_got = 1;
      if (b_hs) begin bvalid = 0; aw_got = 0; w_got = 0; b_cnt = 0; b_count++; end
      if (ar_hs) ar_got = 1;
      if (r_hs) begin rvalid = 0; ar_got = 0; r_cnt = 0; end

      if (p_awvalid && !aw_hs) chk("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
      if (p_wvalid && !w_hs) chk("w_stable", {wvalid, wdata, wstrb}, {1'b1, p_w});
      if (p_arvalid && !ar_hs) chk("ar_stable", {arvalid, araddr}, {1'b1, p_araddr});
      if (awvalid || arvalid) chk("ar_aw_exclusive", {awvalid, arvalid} == 2'b11, 0);
      if (bready) chk("bready_after_aw_w", {aw_got, w_got}, 2'b11);

      if (awvalid) aw_cycles++;
      if (wvalid) w_cycles++;
      if (arvalid) ar_cycles++;

      awready = awvalid && (aw_cnt >= cfg_aw_delay);
      aw_cnt  = awvalid ? aw_cnt + 1 : 0;
      wready  = wvalid && (w_cnt >= cfg_w_delay);
      w_cnt   = wvalid ? w_cnt + 1 : 0;
      arready = arvalid && (ar_cnt >= cfg_ar_delay);
      ar_cnt  = arvalid ? ar_cnt + 1 : 0;

      if (cfg_spurious) begin
        bvalid = 1; rvalid = 1;
        chk("spurious_not_consumed", {bready, rready}, 2'b00);
      end else if (spur_prev) begin
        bvalid = 0; rvalid = 0;
      end
      spur_prev = cfg_spurious;

      if (aw_got && w_got && !bvalid) begin
        if (b_cnt >= cfg_b_delay) begin bvalid = 1; bresp = cfg_bresp; end
        else b_cnt++;
      end
      if (ar_got && !rvalid) begin
        if (r_cnt >= cfg_r_delay) begin rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; end
        else r_cnt++;
      end

      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      p_awvalid = awvalid; p_awaddr = awaddr;
      p_wvalid  = wvalid;  p_w = {wdata, wstrb};
      p_arvalid = arvalid; p_araddr = araddr;
    end
  end

  // Response monitor: pops the scoreboard on every resp_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL resp_unexpected: got resp_valid=1 with rdata %0h resp %0h, required no response (cycle %0d)",
                   resp_rdata, resp_resp, cyc);
        end else begin
          e = sb.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_resp", resp_resp, e.resp);
          chk("resp_cycle", cyc, e.cyc);
          chk("req_ready_low_in_resp", req_ready, 0);
        end
        $display("[TB] cycle %0d resp rdata=%08h resp=%0d", cyc, resp_rdata, resp_resp);
      end
    end
  end

  task automatic do_req(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] erd, input logic [1:0] ers,
                        input int lat);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_wait", req_ready, 1);
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    e.rdata = erd; e.resp = ers; e.cyc = cyc + lat;
    sb.push_back(e);
    $display("[TB] cycle %0d req %s addr=%04h wdata=%08h wstrb=%h", cyc, wr ? "WR" : "RD", addr, wd, ws);
    @(posedge clk); #1;
    req_valid = 0; req_write = ~wr; req_addr = 16'h0003; req_wdata = ~wd; req_wstrb = ~ws;
    if (addr[1:0] != 2'b00)
      chk("misaligned_no_valid", {awvalid, wvalid, arvalid}, 3'b000);
    else if (wr)
      chk("aw_w_payload", {awvalid, wvalid, awaddr, wdata, wstrb, arvalid}, {2'b11, addr, wd, ws, 1'b0});
    else
      chk("ar_payload", {arvalid, araddr, awvalid, wvalid}, {1'b1, addr, 2'b00});
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); #1; n++; end
    if (sb.size() != 0) begin
      chk("resp_timeout", 0, 1);
      sb.delete();
    end
    @(negedge clk);
    chk("req_ready_after_resp", req_ready, 1);
  endtask

  task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
    cfg_aw_delay = aw; cfg_w_delay = w; cfg_b_delay = b; cfg_ar_delay = ar; cfg_r_delay = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, w0, r0, b0;
    #1;
    chk("reset_ready", req_ready, 1);
    chk("reset_valids", {awvalid, wvalid, bready, arvalid, rready, resp_valid}, 6'd0);
    chk("reset_payload", {awaddr, araddr, wdata, wstrb, resp_rdata, resp_resp}, 102'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Zero-wait read of 0xBFF8
    cfg_rdata = 32'h0000_1234; cfg_rresp = 2'b00; set_delays(0, 0, 0, 0, 0);
    r0 = ar_cycles;
    do_req(0, 16'hBFF8, 0, 0, 32'h0000_1234, 2'b00, 3);
    chk("ar_one_cycle", ar_cycles - r0, 1);

    // AW immediately, W after three wait cycles
    cfg_bresp = 2'b00; set_delays(0, 3, 0, 0, 0);
    a0 = aw_cycles; w0 = w_cycles; b0 = b_count;
    do_req(1, 16'h4000, 32'hDEADBEEF, 4'hF, 32'd0, 2'b00, 6);
    chk("aw_cycles_w_late", aw_cycles - a0, 1);
    chk("w_cycles_w_late", w_cycles - w0, 4);
    chk("b_count_w_late", b_count - b0, 1);

    // W first, AW after three wait cycles
    set_delays(3, 0, 0, 0, 0);
    a0 = aw_cycles; w0 = w_cycles; b0 = b_count;
    do_req(1, 16'h0010, 32'h1234_5678, 4'h3, 32'd0, 2'b00, 6);
    chk("aw_cycles_aw_late", aw_cycles - a0, 4);
    chk("w_cycles_aw_late", w_cycles - w0, 1);
    chk("b_count_aw_late", b_count - b0, 1);

    // Misaligned read and write: local SLVERR, no bus traffic
    set_delays(0, 0, 0, 0, 0);
    a0 = aw_cycles; w0 = w_cycles; r0 = ar_cycles;
    do_req(0, 16'h0002, 0, 0, 32'd0, 2'b10, 1);
    do_req(1, 16'h0002, 32'hFFFF_FFFF, 4'hF, 32'd0, 2'b10, 1);
    chk("misaligned_bus_idle", (aw_cycles - a0) + (w_cycles - w0) + (ar_cycles - r0), 0);

    // DECERR write response after five wait cycles on BVALID
    cfg_bresp = 2'b11; set_delays(0, 0, 5, 0, 0);
    do_req(1, 16'h0020, 32'h0BAD_F00D, 4'h5, 32'd0, 2'b11, 8);

    // Read with AR and R backpressure, DECERR passthrough
    cfg_rdata = 32'hCAFE_F00D; cfg_rresp = 2'b11; set_delays(0, 0, 0, 1, 2);
    r0 = ar_cycles;
    do_req(0, 16'h0104, 0, 0, 32'hCAFE_F00D, 2'b11, 6);
    chk("ar_cycles_backpressure", ar_cycles - r0, 2);

    // Unsolicited BVALID/RVALID while idle must be left unconsumed
    cfg_spurious = 1;
    repeat (4) @(negedge clk);
    cfg_spurious = 0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a write
    set_delays(20, 20, 0, 0, 0);
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 16'h1000; req_wdata = 32'h5555_AAAA; req_wstrb = 4'hF;
    $display("[TB] cycle %0d req WR addr=1000 (reset mid-transaction)", cyc);
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    chk("pre_reset_awvalid", {awvalid, wvalid}, 2'b11);
    #1 rst_n = 0;
    #1;
    chk("async_reset_valids", {awvalid, wvalid, bready, arvalid, rready, resp_valid}, 6'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("post_reset_ready", req_ready, 1);
    set_delays(0, 0, 0, 0, 0);
    cfg_rdata = 32'h0000_A5A5; cfg_rresp = 2'b00;
    do_req(0, 16'h0100, 0, 0, 32'h0000_A5A5, 2'b00, 3);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
